// File: rtl/spi_slave_param_if_if.sv
// Bus bundle for spi_slave_param_if: SPI pins, RAM read-data handshake and status pulses.
interface spi_slave_param_if_if #(
    parameter int unsigned DATA_W = 8
);
    logic              MOSI;
    logic              SS_n;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic              cmd_err;
    logic              tx_timeout;
    logic [7:0]        abort_cnt;

    modport slave (
        input  MOSI, SS_n, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, cmd_err, tx_timeout, abort_cnt
    );

    modport master (
        output MOSI, SS_n, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, cmd_err, tx_timeout, abort_cnt
    );
endinterface

// File: rtl/spi_slave_param_if.sv
// SPI slave: receives {cmd[1:0], payload} frames, serves read data after a read-address command.
// Define SPI_SLV_ABORT_CNT_EN to build the saturating aborted-frame counter (abort_cnt tied 0 otherwise).
module spi_slave_param_if #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TX_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 a_rst,
    spi_slave_param_if_if.slave  bus
);
    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WAIT_W  = 8;

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT_TX, SEND, DONE} state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-2:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 rd_ok_q, rd_ok_d;
    logic                 miso_q, miso_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 tmo_q, tmo_d;
    logic [FRAME_W-1:0]   frame_c;
    logic [1:0]           cmd_c;

    // Frame as it stands including the bit being sampled this edge.
    assign frame_c = {shift_q, bus.MOSI};
    assign cmd_c   = frame_c[FRAME_W-1 -: 2];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        tx_d       = tx_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rd_ok_d    = rd_ok_q;
        miso_d     = 1'b0;
        rx_valid_d = 1'b0;
        cmd_err_d  = 1'b0;
        tmo_d      = 1'b0;

        if (bus.SS_n) begin
            state_d    = IDLE;
            shift_d    = '0;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            tx_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    shift_d   = frame_c[FRAME_W-2:0];
                    bit_cnt_d = CNT_W'(1);
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    shift_d   = frame_c[FRAME_W-2:0];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = DONE;
                        if (cmd_c == 2'b11 && !rd_ok_q) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            rx_data_d  = frame_c;
                            rx_valid_d = 1'b1;
                        end
                        if (cmd_c == 2'b10) begin
                            rd_ok_d = 1'b1;
                        end
                        if (cmd_c == 2'b11 && rd_ok_q) begin
                            wait_cnt_d = '0;
                            state_d    = WAIT_TX;
                        end
                    end
                end
                WAIT_TX: begin
                    if (bus.tx_valid) begin
                        miso_d    = bus.tx_data[DATA_W-1];
                        tx_d      = {bus.tx_data[DATA_W-2:0], 1'b0};
                        bit_cnt_d = '0;
                        state_d   = SEND;
                    end else if (wait_cnt_q == WAIT_W'(TX_WAIT_MAX - 1)) begin
                        tmo_d      = 1'b1;
                        rd_ok_d    = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                SEND: begin
                    // MSB already on MISO from the entry edge; DATA_W-1 more bits follow.
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        rd_ok_d   = 1'b0;
                        state_d   = DONE;
                    end else begin
                        miso_d    = tx_q[DATA_W-1];
                        tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            rx_data_q  <= '0;
            tx_q       <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rd_ok_q    <= 1'b0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rd_ok_q    <= rd_ok_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            cmd_err_q  <= cmd_err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.MISO       = miso_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.tx_timeout = tmo_q;

`ifdef SPI_SLV_ABORT_CNT_EN
    logic [7:0] abort_cnt_q, abort_cnt_d;

    // Only frames cut short while shifting in or out count as aborts.
    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (bus.SS_n && (state_q == SHIFT || state_q == SEND) && abort_cnt_q != 8'hFF) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            abort_cnt_q <= '0;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign bus.abort_cnt = abort_cnt_q;
`else
    assign bus.abort_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_param_if.sv
// Scoreboard bench for spi_slave_param_if: DATA_W=8 and DATA_W=12 instances, one active at a time.
module tb_spi_slave_param_if;
    localparam int K_RX   = 0;
    localparam int K_ERR  = 1;
    localparam int K_TMO  = 2;
    localparam int K_SEND = 3;
    localparam int MAX8   = 15;
    localparam int MAX12  = 4;
`ifdef SPI_SLV_ABORT_CNT_EN
    localparam int ABORT_STEP = 1;
`else
    localparam int ABORT_STEP = 0;
`endif

    typedef struct {
        int          kind;
        logic [17:0] data;
        int          cyc;
        int          width;
    } exp_t;

    logic        clk = 1'b0;
    logic        a_rst = 1'b1;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data = '0;
    logic        sel = 1'b0;
    logic        miso_dc = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q[$];

    spi_slave_param_if_if #(.DATA_W(8))  bus8 ();
    spi_slave_param_if_if #(.DATA_W(12)) bus12 ();

    assign bus8.MOSI      = mosi;
    assign bus8.SS_n      = sel ? 1'b1 : ss_n;
    assign bus8.tx_data   = tx_data[7:0];
    assign bus8.tx_valid  = tx_valid & ~sel;
    assign bus12.MOSI     = mosi;
    assign bus12.SS_n     = sel ? ss_n : 1'b1;
    assign bus12.tx_data  = tx_data[11:0];
    assign bus12.tx_valid = tx_valid & sel;

    spi_slave_param_if #(.DATA_W(8), .TX_WAIT_MAX(MAX8)) dut8 (
        .clk(clk), .a_rst(a_rst), .bus(bus8.slave));
    spi_slave_param_if #(.DATA_W(12), .TX_WAIT_MAX(MAX12)) dut12 (
        .clk(clk), .a_rst(a_rst), .bus(bus12.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rxv, cev, tov, mi;
    logic [17:0] rxd;
    logic [7:0]  abc;
    assign rxv = sel ? bus12.rx_valid   : bus8.rx_valid;
    assign cev = sel ? bus12.cmd_err    : bus8.cmd_err;
    assign tov = sel ? bus12.tx_timeout : bus8.tx_timeout;
    assign mi  = sel ? bus12.MISO       : bus8.MISO;
    assign rxd = sel ? 18'(bus12.rx_data) : 18'(bus8.rx_data);
    assign abc = sel ? bus12.abort_cnt  : bus8.abort_cnt;

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        miscompares++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) fail(name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every pulse, collects MISO words, flags stray MISO activity.
    exp_t        e_m;
    int          kind_m;
    int          nb = 0;
    logic [15:0] sh = '0;
    always @(negedge clk) begin
        if (!a_rst) begin
            if (rxv || cev || tov) begin
                kind_m = rxv ? K_RX : (cev ? K_ERR : K_TMO);
                vectors++;
                if (q.size() == 0) begin
                    fail("unexpected_pulse", 32'(kind_m), 32'hFFFF_FFFF);
                end else begin
                    e_m = q.pop_front();
                    if (e_m.kind != kind_m)
                        fail("pulse_kind", 32'(kind_m), 32'(e_m.kind));
                    else if (kind_m == K_RX && rxd !== e_m.data)
                        fail("rx_data", 32'(rxd), 32'(e_m.data));
                    else if (cyc != e_m.cyc)
                        fail("pulse_cycle", 32'(cyc), 32'(e_m.cyc));
                end
            end else if (q.size() > 0 && q[0].kind != K_SEND && cyc > q[0].cyc) begin
                e_m = q.pop_front();
                vectors++;
                fail("missing_pulse", 32'hFFFF_FFFF, 32'(e_m.kind));
            end
            if (q.size() > 0 && q[0].kind == K_SEND && cyc >= q[0].cyc) begin
                sh = {sh[14:0], mi};
                nb++;
                if (nb == q[0].width) begin
                    e_m = q.pop_front();
                    vectors++;
                    if (sh !== e_m.data[15:0]) fail("miso_word", 32'(sh), 32'(e_m.data));
                    nb = 0;
                    sh = '0;
                end
            end else if (mi && !miso_dc) begin
                fail("miso_idle", 32'(mi), 32'h0);
            end
        end
    end

    task automatic push(input int kind, input logic [17:0] data, input int c, input int w);
        exp_t e;
        e.kind = kind; e.data = data; e.cyc = c; e.width = w;
        q.push_back(e);
    endtask

    // Drives bits[len-1:0] MSB first, one per edge; expectation lands len cycles later.
    task automatic frame(input logic [17:0] bits, input int len, input int kind, input logic [17:0] data);
        if (kind >= 0) push(kind, data, cyc + len, 0);
        for (int i = len - 1; i >= 0; i--) begin
            ss_n = 1'b0;
            mosi = bits[i];
            @(negedge clk);
        end
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_tx(input logic [15:0] d, input int w);
        push(K_SEND, 18'(d), cyc + 1, w);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_data"}, 32'(rxd), 32'h0);
        check({tag, "_rx_valid"}, 32'(rxv), 32'h0);
        check({tag, "_miso"}, 32'(mi), 32'h0);
        check({tag, "_cmd_err"}, 32'(cev), 32'h0);
        check({tag, "_tx_timeout"}, 32'(tov), 32'h0);
        check({tag, "_abort_cnt"}, 32'(abc), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected end", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);

        // Read-data with no read address: error pulse only.
        frame(18'h300, 10, K_ERR, 18'h0); end_frame();
        frame(18'h0A5, 10, K_RX, 18'h0A5); end_frame();
        frame(18'h13C, 10, K_RX, 18'h13C); end_frame();

        // Abort after five bits.
        frame(18'h15, 5, -1, 18'h0); end_frame();
        check("abort5_rx_data", 32'(rxd), 32'h13C);
        check("abort5_cnt", 32'(abc), 32'(ABORT_STEP));

        // tx_valid outside WAIT_TX is ignored; then a full read transfer of 0xC3.
        tx_data = 16'hFFFF; tx_valid = 1'b1;
        frame(18'h20F, 10, K_RX, 18'h20F); end_frame();
        tx_valid = 1'b0; tx_data = '0;
        frame(18'h355, 10, K_RX, 18'h355); idle(2);
        send_tx(16'h00C3, 8); idle(10); end_frame();
        frame(18'h300, 10, K_ERR, 18'h0); end_frame();

        // Repeated read address keeps the flag set.
        frame(18'h211, 10, K_RX, 18'h211); end_frame();
        frame(18'h222, 10, K_RX, 18'h222); end_frame();
        frame(18'h3F0, 10, K_RX, 18'h3F0); idle(1);
        send_tx(16'h005A, 8); idle(10); end_frame();

        // Timeout exactly MAX8 cycles after entering WAIT_TX, flag cleared after.
        frame(18'h233, 10, K_RX, 18'h233); end_frame();
        push(K_RX, 18'h3CC, cyc + 10, 0);
        push(K_TMO, 18'h0, cyc + 10 + MAX8, 0);
        frame(18'h3CC, 10, -1, 18'h0); idle(20); end_frame();
        frame(18'h300, 10, K_ERR, 18'h0); end_frame();

        // SS_n rising on the last bit edge is an abort.
        frame(18'h0FF, 9, -1, 18'h0);
        ss_n = 1'b1; mosi = 1'b1;
        @(negedge clk); @(negedge clk);
        mosi = 1'b0;
        check("lastbit_rx_data", 32'(rxd), 32'h3CC);
        check("lastbit_cnt", 32'(abc), 32'(2 * ABORT_STEP));

        // Read address survives SS_n high; leaving WAIT_TX early is not counted.
        frame(18'h2AB, 10, K_RX, 18'h2AB); end_frame(); idle(3);
        frame(18'h3EE, 10, K_RX, 18'h3EE); idle(3); end_frame();
        check("waittx_exit_cnt", 32'(abc), 32'(2 * ABORT_STEP));

        // DATA_W=12: reset in the middle of SEND, then a clean write frame.
        sel = 1'b1; idle(2);
        frame(18'h2000, 14, K_RX, 18'h2000); end_frame();
        frame(18'h3ABC, 14, K_RX, 18'h3ABC); idle(1);
        miso_dc = 1'b1;
        tx_data = 16'h09A5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = '0;
        idle(3);
        #2 a_rst = 1'b1; ss_n = 1'b1;
        #1 check_zero("midsend_reset");
        @(negedge clk);
        a_rst = 1'b0;
        miso_dc = 1'b0;
        frame(18'h15C3, 14, K_RX, 18'h15C3); end_frame();

        idle(5);
        check("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_slave_param_if.md
SPI_SLAVE_PARAM_IF -- requirements
Module: spi_slave_param_if

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 4..16.
REQ-002 Parameter TX_WAIT_MAX, default 15: maximum cycles spent in WAIT_TX for tx_valid; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 a_rst  input  1  asynchronous, active-high reset.
REQ-005 MOSI  input  1  serial data from master, MSB first.
REQ-006 SS_n  input  1  slave select, active low; 1 aborts or ends any transaction.
REQ-007 tx_data  input  DATA_W  read data from RAM.
REQ-008 tx_valid  input  1  tx_data is valid this cycle.
REQ-009 MISO  output  1  serial data to master, MSB first.
REQ-010 rx_data  output  DATA_W+2  received frame {cmd[1:0], payload}.
REQ-011 rx_valid  output  1  one-cycle pulse: rx_data holds a complete frame.
REQ-012 cmd_err  output  1  one-cycle pulse: read-data command with no prior read-address command.
REQ-013 tx_timeout  output  1  one-cycle pulse: tx_valid did not arrive within TX_WAIT_MAX cycles.
REQ-014 abort_cnt  output  8  count of aborted frames (see Configuration).

Function
REQ-015 Frame length SHALL be F = DATA_W+2 bits; MOSI is sampled on every clk edge while SS_n=0, and the first bit is sampled on the first edge with SS_n=0.
REQ-016 Commands SHALL be 00 write address, 01 write data, 10 read address, 11 read data.
REQ-017 States SHALL be IDLE, SHIFT, WAIT_TX, SEND and DONE.
REQ-018 IDLE SHALL go to SHIFT when SS_n=0, sampling bit F-1.
REQ-019 SHIFT SHALL sample the remaining bits; on bit 0, rx_data = full frame and rx_valid = 1 for exactly one cycle.
REQ-020 The rx_valid pulse SHALL be registered, one cycle after the last bit edge; rx_data SHALL hold until the next complete frame.
REQ-021 After cmd 00, 01 or 10, SHIFT SHALL go to DONE.
REQ-022 Cmd 10 SHALL set the internal rd_addr_ok flag.
REQ-023 After cmd 11 with rd_addr_ok=1, SHIFT SHALL go to WAIT_TX.
REQ-024 After cmd 11 with rd_addr_ok=0: no rx_valid, cmd_err pulses once, and SHIFT goes to DONE.
REQ-025 WAIT_TX SHALL latch tx_data on the first cycle tx_valid=1 and go to SEND.
REQ-026 If TX_WAIT_MAX cycles elapse in WAIT_TX without tx_valid, tx_timeout pulses once and WAIT_TX goes to DONE; rd_addr_ok is cleared.
REQ-027 SEND SHALL drive MISO with the latched bits DATA_W-1..0, one per cycle, then go to DONE and clear rd_addr_ok.
REQ-028 MISO SHALL be 0 outside SEND.
REQ-029 DONE SHALL ignore MOSI until SS_n=1.
REQ-030 SS_n=1 in any state SHALL force IDLE on the next edge and clear the bit counter and shift register.
REQ-031 A partial frame SHALL never assert rx_valid; rx_data SHALL be unchanged after an abort.
REQ-032 SS_n rising on the same edge as the last frame bit SHALL be treated as an abort.
REQ-033 rd_addr_ok SHALL survive SS_n deassertion between transactions.
REQ-034 A second cmd 10 before cmd 11 SHALL keep rd_addr_ok set; the latest address is the RAM's concern.
REQ-035 tx_valid outside WAIT_TX SHALL be ignored.

Reset
REQ-036 a_rst=1 SHALL immediately force: state IDLE; MISO, rx_valid, cmd_err and tx_timeout = 0; rx_data = 0; rd_addr_ok = 0; counters = 0; abort_cnt = 0.
REQ-037 Reset mid-frame or mid-SEND SHALL discard the transaction with no pulses.
REQ-038 After release, the first SS_n=0 edge SHALL start a new frame.

Configuration
REQ-039 Macro SPI_SLV_ABORT_CNT_EN defined: abort_cnt increments, saturating at 255, each time SS_n rises while in SHIFT or SEND.
REQ-040 Macro SPI_SLV_ABORT_CNT_EN undefined: the abort_cnt port SHALL exist, be tied to 0, and no counter logic is generated.

Verification
REQ-041 DATA_W=8: SS_n=0, shift 10'b00_1010_0101, then SS_n=1 -> rx_data=0x0A5, one-cycle rx_valid, MISO stays 0.
REQ-042 Frame 10_00001111, then frame 11_xxxxxxxx, tx_valid after 3 cycles with tx_data=0xC3 -> MISO serial 1,1,0,0,0,0,1,1, and rd_addr_ok cleared after the transfer.
REQ-043 Frame 11_00000000 after reset -> cmd_err one pulse, no rx_valid, MISO=0.
REQ-044 Read-address then read-data with tx_valid held 0 -> tx_timeout pulses exactly TX_WAIT_MAX cycles after entering WAIT_TX.
REQ-045 SS_n high after 5 bits, with SPI_SLV_ABORT_CNT_EN defined -> no rx_valid, rx_data unchanged, abort_cnt=1; with it undefined, abort_cnt=0.
REQ-046 DATA_W=12 and a_rst pulsed mid-SEND -> all outputs 0 at once; the next 14-bit write frame decodes correctly.
